// File: rtl/ps2_host_tx_if.sv
// Host-side command interface of the PS/2 transmitter: byte handshake plus transfer status.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_err, timeout_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_err, timeout_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter driving open-collector clock/data enables.
// Optional transfer watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic         Clk,
    input  logic         Reset,
    ps2_host_tx_if.slave host,
    input  logic         ps2_nclk,
    input  logic         ndata,
    output logic         clk_oe,
    output logic         data_oe
);

    localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StSend,
        StAck,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic            parity_q, parity_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
    logic            data_oe_q, data_oe_d;
    logic            ack_err_q, ack_err_d;
    logic            done;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;
    logic fall;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false fall.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_nclk;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ndata;
            data_sync_q <= data_meta_q;
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned ToutW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ToutW-1:0] ToutLast = ToutW'(TIMEOUT_CYCLES - 1);

    logic [ToutW-1:0] tout_cnt_q, tout_cnt_d;
    logic             tout_err_q, tout_err_d;
    logic             tout_now;
`endif

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        data_oe_d = data_oe_q;
        ack_err_d = ack_err_q;
        done      = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        tout_cnt_d = tout_cnt_q;
        tout_err_d = tout_err_q;
        tout_now   = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (host.tx_valid) begin
                    data_d    = host.tx_data;
                    parity_d  = ~^host.tx_data;
                    ack_err_d = 1'b0;
                    bit_cnt_d = '0;
                    inh_cnt_d = '0;
                    data_oe_d = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
                    tout_err_d = 1'b0;
`endif
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (inh_cnt_q == InhLast) begin
                    data_oe_d = 1'b1;
                    state_d   = StRts;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            StRts: begin
`ifdef PS2_TX_TIMEOUT_EN
                tout_cnt_d = '0;
`endif
                state_d = StSend;
            end
            StSend: begin
                // bit_cnt_q holds the number of falls already seen in this frame.
                if (fall) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = StAck;
                    end
                end
            end
            StAck: begin
                if (fall) begin
                    ack_err_d = data_sync_q;
                    state_d   = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (clk_sync_q && data_sync_q) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Normal completion in the same cycle takes priority over the watchdog.
        if (state_q inside {StSend, StAck, StWaitIdle}) begin
            if (tout_cnt_q == ToutLast) begin
                if (!done) begin
                    tout_now   = 1'b1;
                    tout_err_d = 1'b1;
                    done       = 1'b1;
                    data_oe_d  = 1'b0;
                    state_d    = StIdle;
                end
            end else begin
                tout_cnt_d = tout_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            data_q    <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            data_oe_q <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            data_oe_q <= data_oe_d;
            ack_err_q <= ack_err_d;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tout_cnt_q <= '0;
            tout_err_q <= 1'b0;
        end else begin
            tout_cnt_q <= tout_cnt_d;
            tout_err_q <= tout_err_d;
        end
    end

    assign host.timeout_err = tout_err_q | tout_now;
`else
    logic unused_timeout;
    assign unused_timeout   = ^TIMEOUT_CYCLES;
    assign host.timeout_err = 1'b0;
`endif

    assign clk_oe        = (state_q == StInhibit) || (state_q == StRts);
    assign data_oe       = data_oe_q;
    assign host.busy     = (state_q != StIdle);
    assign host.tx_ready = (state_q == StIdle);
    assign host.done     = done;
    assign host.ack_err  = ack_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised bench for ps2_host_tx: a PS/2 device model clocks frames and the
// received bits and enable pattern are compared with frame bits built from the byte.
module tb_ps2_host_tx;

    localparam int Inhibit = 20;
    localparam int Timeout = 1000;

    logic Clk = 1'b0;
    logic Reset;
    logic dev_clk, dev_data;
    logic ps2_nclk, ndata;
    logic clk_oe, data_oe;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic done_ack = 1'b0;
    logic done_terr = 1'b0;

    ps2_host_tx_if host ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inhibit),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .host    (host),
        .ps2_nclk(ps2_nclk),
        .ndata   (ndata),
        .clk_oe  (clk_oe),
        .data_oe (data_oe)
    );

    // Wired-AND open-collector lines.
    assign ps2_nclk = dev_clk & ~clk_oe;
    assign ndata    = dev_data & ~data_oe;

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (host.done) begin
            done_cnt  <= done_cnt + 1;
            done_ack  <= host.ack_err;
            done_terr <= host.timeout_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Frame bit idx on the wire: 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == 9) return ($countones(d) % 2 == 0);
        return 1'b1;
    endfunction

    // mode 0: full frame, 1: reset after fall 4, 2: device stalls after fall 3
    task automatic send(input logic [7:0] d, input bit do_ack, input int mode);
        int n;
        int half;
        int t_rts;
        int d0;
        logic [10:0] rx;
        half = $urandom_range(7, 12);
        rx = '0;
        n = 0;
        while (!host.tx_ready && n < 200) begin
            step(1);
            n++;
        end
        check("ready_before", host.tx_ready, 1);
        d0 = done_cnt;
        host.tx_data  = d;
        host.tx_valid = 1'b1;
        step(1);
        host.tx_valid = 1'b0;
        check("busy_after_accept", host.busy, 1);
        check("ack_err_cleared", host.ack_err, 0);
        n = 0;
        while (clk_oe && !data_oe && n < 100) begin
            step(1);
            n++;
        end
        check("inhibit_len", n, Inhibit);
        check("rts_oe", {clk_oe, data_oe}, 2'b11);
        t_rts = cyc;
        step(1);
        check("send_oe", {clk_oe, data_oe}, 2'b01);
        rx[0] = ndata;
        for (int k = 1; k <= 11; k++) begin
            if (mode == 2 && k > 3) break;
            if (k == 11 && do_ack) dev_data = 1'b0;
            step(half / 2);
            dev_clk = 1'b0;
            step(half - 1);
            if (k <= 10) check($sformatf("oe_after_fall%0d", k), data_oe, !frame_bit(d, k));
            if (mode == 1 && k == 4) begin
                Reset = 1'b1;
                step(1);
                Reset = 1'b0;
                dev_clk = 1'b1;
                check("rst_oe", {clk_oe, data_oe}, 2'b00);
                check("rst_busy", host.busy, 0);
                check("rst_ready", host.tx_ready, 1);
                return;
            end
            step(1);
            dev_clk = 1'b1;
            if (k <= 10) rx[k] = ndata;
            step(half);
        end
        if (mode == 2) begin
            host.tx_data  = 8'hAA;
            host.tx_valid = 1'b1;
            n = 0;
            while (!host.done && n < 3000) begin
                step(1);
                n++;
            end
            check("to_done", host.done, 1);
            check("to_cycle", cyc - t_rts, Timeout);
            check("to_err_at_done", host.timeout_err, 1);
            check("to_not_accepted", host.busy, 1);
            step(1);
            check("to_idle_oe", {clk_oe, data_oe}, 2'b00);
            check("to_ready", host.tx_ready, 1);
            check("to_err_hold", host.timeout_err, 1);
            step(1);
            host.tx_valid = 1'b0;
            check("to_accept", host.busy, 1);
            check("to_err_clr", host.timeout_err, 0);
            Reset = 1'b1;
            step(1);
            Reset = 1'b0;
            return;
        end
        step(2);
        dev_data = 1'b1;
        step(20);
        check("rx_start", rx[0], 0);
        check("rx_byte", rx[8:1], d);
        check("rx_parity", rx[9], frame_bit(d, 9));
        check("rx_stop", rx[10], 1);
        check("done_once", done_cnt - d0, 1);
        check("ack_err_at_done", done_ack, !do_ack);
        check("timeout_err_at_done", done_terr, 0);
        check("ack_err_hold", host.ack_err, !do_ack);
        check("ready_after", host.tx_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        host.tx_data = 8'h00;
        host.tx_valid = 1'b0;
        step(3);
        Reset = 1'b0;
        check("reset_oe", {clk_oe, data_oe}, 2'b00);
        check("reset_busy", host.busy, 0);
        check("reset_ready", host.tx_ready, 1);
        check("reset_done", host.done, 0);
        check("reset_ack_err", host.ack_err, 0);
        check("reset_timeout_err", host.timeout_err, 0);

        send(8'hED, 1'b1, 0);
        send(8'h01, 1'b1, 0);
        send(8'($urandom), 1'b0, 0);
        send(8'($urandom), 1'b1, 0);
        for (int i = 0; i < 6; i++) send(8'($urandom), 1'($urandom_range(0, 1)), 0);
        send(8'($urandom), 1'b1, 1);
        send(8'h01, 1'b1, 0);
`ifdef PS2_TX_TIMEOUT_EN
        send(8'($urandom), 1'b1, 2);
        send(8'($urandom), 1'b1, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
